// File: rtl/imem_fetch_resp_if.sv
// Fetch request/response bus between the PC-side fetcher (master) and the
// instruction-memory responder (slave).
interface imem_fetch_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_err
  );
endinterface

// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: accepts one word fetch, waits a fixed number
// of cycles, then presents the instruction (or a NOP plus error flag for a
// misaligned / out-of-range address) under a valid/ready handshake.
// A word-write load port fills the array for boot or test.
module imem_fetch_resp #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  imem_fetch_resp_if.slave   bus,
  input  logic               ld_en,
  input  logic [31:0]        ld_addr,
  input  logic [31:0]        ld_data
);

  localparam int         IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready;
  logic              accept;
  logic              load_resp;
  logic [IDX_W-1:0]  req_idx_p0;
  logic              req_err_p0;
  logic [31:0]       resp_instr_q;
  logic              resp_err_q;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              unused_ld_bits;

  // Word index is addr[31:2], compared unsigned against the array depth.
  function automatic logic word_in_range(input logic [31:0] a);
    return ({2'b00, a[31:2]} < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || !word_in_range(a);
  endfunction

  // The load port ignores the byte offset within a word.
  assign unused_ld_bits = ^ld_addr[1:0];

  // Next-state and handshake decode. The counter is loaded with LATENCY on
  // accept, so a request accepted at edge N is presented after edge N+1+LATENCY.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready     = 1'b0;
    accept    = 1'b0;
    load_resp = 1'b0;
    case (state_q)
      IDLE: begin
        ready  = 1'b1;
        accept = bus.req_valid;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        ready = bus.resp_ready;
        if (bus.resp_ready) begin
          state_d = IDLE;
          accept  = bus.req_valid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = WAIT;
      cnt_d   = LAT_CNT;
    end
  end

  // Control state register; reset drops any pending request or response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request stage: capture word index and error status at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_idx_p0 <= bus.req_addr[IDX_W+1:2];
      req_err_p0 <= addr_err(bus.req_addr);
    end
  end

  // Response stage: array read on the edge that enters RESP (old data on a
  // same-edge load), held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_instr_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else if (load_resp) begin
      resp_instr_q <= req_err_p0 ? NOP_INSTR : mem[req_idx_p0];
      resp_err_q   <= req_err_p0;
    end
  end

  // Load port write; out-of-range words are silently dropped.
  always_ff @(posedge clk) begin
    if (ld_en && word_in_range(ld_addr)) begin
      mem[ld_addr[IDX_W+1:2]] <= ld_data;
    end
  end

  assign bus.req_ready  = ready & reset;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_instr = resp_instr_q;
  assign bus.resp_err   = resp_err_q;

endmodule
